rf_dump_reader: RTL and testbench
=================================

# rf_dump_reader

Debug reader for the register file's third read port (`ra3`/`rd3`) on the MIPS datapath. On a start pulse it sweeps a range of register addresses and captures each `rd3` word. It then streams each word out over a valid/ready interface to a host-side consumer such as a UART bridge or a trace buffer. It is the consumer counterpart of the datapath's debug read port, and the datapath needs no changes to host it.

## Interface
Parameters:
- `FIRST_REG`, default 0: first register index dumped (0–31).
- `LAST_REG`, default 31: last register index dumped (0–31). `FIRST_REG` ≤ `LAST_REG` is required; elaboration fails otherwise.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `abort`  in  1  terminate an in-progress dump; ignored in IDLE and DONE.
- `ra3`  out  5  register address to the datapath debug port.
- `rd3`  in  32  register data from the datapath debug port; combinational with `ra3`.
- `dump_valid`  out  1  `dump_data` / `dump_idx` / `dump_last` are valid.
- `dump_ready`  in  1  consumer accepts the word.
- `dump_data`  out  32  captured register value.
- `dump_idx`  out  5  register index of `dump_data`.
- `dump_last`  out  1  the current word is `LAST_REG`.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a dump completes without abort.
- `freeze`  out  1  equals `busy`; the SoC may use it to gate the core for an atomic snapshot.

## Operation
- FSM states: IDLE, READ, SEND, DONE. There is one 5-bit index counter `idx`.
- IDLE:
  - `ra3`=0 and `dump_valid`=0.
  - On `start`=1: `idx`←`FIRST_REG`, then go to READ.
- READ (one cycle):
  - `ra3`=`idx`.
  - At the edge: `dump_data`←`rd3`, `dump_idx`←`idx`, `dump_last`←(`idx`==`LAST_REG`), `dump_valid`←1, then go to SEND.
- SEND:
  - `ra3`=`idx`, and `dump_valid`=1 is held.
  - `dump_data`, `dump_idx` and `dump_last` are stable until the handshake.
  - Handshake = `dump_valid` & `dump_ready` at a rising edge. On a handshake:
    - if `dump_last`, go to DONE;
    - otherwise `idx`←`idx`+1, then go to READ.
  - Without `dump_ready`, stay in SEND indefinitely.
- DONE (one cycle): `done`=1, `dump_valid`=0, then go to IDLE.
- Abort:
  - `abort`=1 in READ or SEND → IDLE at the next edge. `dump_valid` goes to 0 and `done` is not pulsed.
  - If `abort` coincides with a SEND handshake, that word counts as transferred and no further words are produced.
- `start` while `busy` is ignored. `start` and `abort` both high in IDLE: `start` wins.
- `idx` never wraps, because `LAST_REG` ≤ 31 terminates the sweep. A `FIRST_REG`=`LAST_REG` dump produces exactly one word with `dump_last`=1.
- Register 0 is dumped as whatever `rd3` returns; the block applies no special case.

## Timing
- Reset values:
  - state=IDLE, `idx`=0;
  - `ra3`=0, `dump_valid`=0, `dump_data`=0, `dump_idx`=0, `dump_last`=0;
  - `busy`=0, `done`=0, `freeze`=0.
- Reset mid-dump has the same effect as abort, but also clears the data registers.
- `start` sampled at edge 0 → READ in cycle 1, with `ra3`=`FIRST_REG` → first `dump_valid` in cycle 2.
- With `dump_ready` held high:
  - word k is valid in cycle 2+2k;
  - throughput is 1 word per 2 cycles;
  - for N words, the last word is valid in cycle 2N, `done` is high in cycle 2N+1, and `busy` is low from cycle 2N+2.
- Each consumer stall cycle in SEND delays all later events by one cycle.
- `rd3` is sampled only at the end of READ. Register writes after that edge do not alter the captured word.
- Outputs `dump_*`, `busy`, `done` and `freeze` are registered or state-decoded; there is no combinational path from `dump_ready` to `dump_valid`.

## Test plan
- Full dump, ready always high. Preload regs with value 0x1000+i (reg0 = 0) and pulse `start`.
  - Required: 32 words with `dump_idx` 0..31, data matching the preload, and `dump_last` only on idx 31.
  - Required: `done` in cycle 65 and `busy` low in cycle 66.
- Backpressure: drop `dump_ready` for 3 cycles on word 5.
  - Required: `dump_data`/`dump_idx` stay frozen and `ra3` stays 5.
  - Required: no word is lost or duplicated, and `done` is delayed by 3 cycles.
- Range `FIRST_REG`=8, `LAST_REG`=8:
  - Required: exactly one word, idx 8, with `dump_last`=1; `done` in cycle 3.
- Abort in SEND of word 3 with `dump_ready`=0:
  - Required: IDLE next cycle, `dump_valid`=0, no `done`, and `busy`=0.
- Abort coinciding with the handshake of word 3:
  - Required: word 3 is accepted, no word 4 follows, and there is no `done`.
- Second `start` mid-dump is ignored.
- Sync `rst` asserted in READ returns all outputs to reset values on the next cycle.
- A new `start` after reset produces a clean dump from `FIRST_REG`.

Source files
------------

// File: rtl/rf_dump_reader.sv
// Debug dump engine for the register file's third read port: sweeps a register range,
// captures each rd3 word and streams it out over a valid/ready interface.
module rf_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  ra3,
    input  logic [31:0] rd3,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic [4:0]  dump_idx,
    output logic        dump_last,
    output logic        busy,
    output logic        done,
    output logic        freeze
);

    generate
        if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
            $error("rf_dump_reader: need FIRST_REG <= LAST_REG <= 31");
        end
    endgenerate

    localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
    localparam logic [4:0] LastIdx  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StSend,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  didx_q, didx_d;
    logic        last_q, last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= '0;
            didx_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        didx_d  = didx_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                // start has priority over a simultaneous abort here
                if (start) begin
                    idx_d   = FirstIdx;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    data_d  = rd3;
                    didx_d  = idx_q;
                    last_d  = (idx_q == LastIdx);
                    state_d = StSend;
                end
            end
            StSend: begin
                // an abort on the handshake edge still counts the word as delivered
                if (abort) begin
                    state_d = StIdle;
                end else if (dump_ready) begin
                    if (last_q) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        dump_valid = (state_q == StSend);
        done       = (state_q == StDone);
        busy       = (state_q != StIdle);
        freeze     = busy;
        ra3        = (state_q == StRead || state_q == StSend) ? idx_q : 5'd0;
    end

    assign dump_data = data_q;
    assign dump_idx  = didx_q;
    assign dump_last = last_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (dump_valid && !dump_ready && !abort) |=> (dump_valid && $stable(dump_data)
                                                   && $stable(dump_idx)));

    a_idx_range: assert property (@(posedge clk) disable iff (rst)
        busy |-> (idx_q <= LastIdx));

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: cycle tables, scoreboarded word stream, and timing sequences.
module tb_rf_dump_reader;

    logic        clk;
    logic        rst;
    logic        start, abort, ready;
    logic [4:0]  ra3;
    logic [31:0] rd3;
    logic        dump_valid, dump_last, busy, done, freeze;
    logic [31:0] dump_data;
    logic [4:0]  dump_idx;

    logic        start8, abort8, ready8;
    logic [4:0]  ra3_8;
    logic [31:0] rd3_8;
    logic        valid8, last8, busy8, done8, freeze8;
    logic [31:0] data8;
    logic [4:0]  idx8;

    logic [31:0] regs [32];

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
    } word_t;

    typedef struct packed {
        logic       start;
        logic       abort;
        logic       ready;
        logic       ev;
        logic       eb;
        logic       ed;
        logic [4:0] era3;
    } vec_t;

    word_t exp_q[$];
    word_t exp8_q[$];
    word_t w_m, w_m8;
    vec_t  tbl [21];

    assign rd3   = regs[ra3];
    assign rd3_8 = regs[ra3_8];

    rf_dump_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .ra3        (ra3),
        .rd3        (rd3),
        .dump_valid (dump_valid),
        .dump_ready (ready),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_last  (dump_last),
        .busy       (busy),
        .done       (done),
        .freeze     (freeze)
    );

    rf_dump_reader #(.FIRST_REG(8), .LAST_REG(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .abort      (abort8),
        .ra3        (ra3_8),
        .rd3        (rd3_8),
        .dump_valid (valid8),
        .dump_ready (ready8),
        .dump_data  (data8),
        .dump_idx   (idx8),
        .dump_last  (last8),
        .busy       (busy8),
        .done       (done8),
        .freeze     (freeze8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_reg(input int i);
        return (i == 0) ? 32'h0 : 32'h1000 + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int f, input int l);
        for (int i = f; i <= l; i++) begin
            exp_q.push_back('{exp_reg(i), 5'(i), (i == 31)});
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ra3"}, 32'(ra3), 0);
        chk({tag, "_valid"}, 32'(dump_valid), 0);
        chk({tag, "_data"}, dump_data, 0);
        chk({tag, "_idx"}, 32'(dump_idx), 0);
        chk({tag, "_last"}, 32'(dump_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_freeze"}, 32'(freeze), 0);
    endtask

    // Full 32-word dump with ready held high; cycle t is the period after edge t-1.
    task automatic run_full();
        push_words(0, 31);
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 66; t++) begin
            chk("full_valid", 32'(dump_valid), 32'(t >= 2 && t <= 64 && (t % 2) == 0));
            chk("full_done", 32'(done), 32'(t == 65));
            chk("full_busy", 32'(busy), 32'(t <= 65));
            chk("full_freeze", 32'(freeze), 32'(t <= 65));
            chk("full_ra3", 32'(ra3), (t <= 64) ? 32'((t - 1) / 2) : 32'd0);
            if (t < 66) step();
        end
        chk("full_queue_drained", 32'(exp_q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && dump_valid && ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: actual idx %0d, required none", dump_idx);
            end else begin
                w_m = exp_q.pop_front();
                chk("word_data", dump_data, w_m.data);
                chk("word_idx", 32'(dump_idx), 32'(w_m.idx));
                chk("word_last", 32'(dump_last), 32'(w_m.last));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid8 && ready8) begin
            if (exp8_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word8: actual idx %0d, required none", idx8);
            end else begin
                w_m8 = exp8_q.pop_front();
                chk("word8_data", data8, w_m8.data);
                chk("word8_idx", 32'(idx8), 32'(w_m8.idx));
                chk("word8_last", 32'(last8), 32'(w_m8.last));
            end
        end
    end

    initial begin
        //          start abort ready  v  busy done ra3
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

        for (int i = 0; i < 32; i++) regs[i] = exp_reg(i);
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b1;
        start8 = 1'b0;
        abort8 = 1'b0;
        ready8 = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_reset_outputs("reset");
        chk("reset_busy8", 32'(busy8), 0);

        // Single-register range 8..8
        exp8_q.push_back('{exp_reg(8), 5'd8, 1'b1});
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("r8_c1_busy", 32'(busy8), 1);
        chk("r8_c1_ra3", 32'(ra3_8), 8);
        chk("r8_c1_valid", 32'(valid8), 0);
        step();
        chk("r8_c2_valid", 32'(valid8), 1);
        chk("r8_c2_last", 32'(last8), 1);
        step();
        chk("r8_c3_done", 32'(done8), 1);
        chk("r8_c3_valid", 32'(valid8), 0);
        step();
        chk("r8_c4_busy", 32'(busy8), 0);
        chk("r8_c4_done", 32'(done8), 0);
        chk("r8_queue_drained", 32'(exp8_q.size()), 0);

        run_full();

        // Backpressure on word 5, a late write to reg 5, and an ignored second start
        push_words(0, 31);
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 69; t++) begin
            chk("bp_done", 32'(done), 32'(t == 68));
            chk("bp_busy", 32'(busy), 32'(t <= 68));
            if (t >= 12 && t <= 15) begin
                chk("bp_hold_valid", 32'(dump_valid), 1);
                chk("bp_hold_idx", 32'(dump_idx), 5);
                chk("bp_hold_data", dump_data, 32'h1005);
                chk("bp_hold_ra3", 32'(ra3), 5);
            end
            ready = !(t >= 12 && t <= 14);
            start = (t == 20);
            if (t == 13) regs[5] = 32'hDEAD_BEEF;
            if (t < 69) step();
        end
        start = 1'b0;
        ready = 1'b1;
        regs[5] = exp_reg(5);
        chk("bp_queue_drained", 32'(exp_q.size()), 0);

        // Abort while stalled on word 3, then abort on the word-3 handshake
        push_words(0, 2);
        push_words(0, 3);
        for (int i = 0; i < 21; i++) begin
            chk("tbl_valid", 32'(dump_valid), 32'(tbl[i].ev));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].eb));
            chk("tbl_done", 32'(done), 32'(tbl[i].ed));
            chk("tbl_ra3", 32'(ra3), 32'(tbl[i].era3));
            start = tbl[i].start;
            abort = tbl[i].abort;
            ready = tbl[i].ready;
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b1;
        chk("tbl_queue_drained", 32'(exp_q.size()), 0);

        // Synchronous reset while reading word 2
        push_words(0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t < 5; t++) step();
        chk("rstrd_pre_ra3", 32'(ra3), 2);
        chk("rstrd_pre_data", dump_data, 32'h1001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("rst_in_read");
        chk("rstrd_queue_drained", 32'(exp_q.size()), 0);

        run_full();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
